// File: rtl/sprite_draw_queue_if.sv
// Byte-stream input, dequeue handshake and head-entry view of the sprite draw queue.
interface sprite_draw_queue_if #(
    parameter int CNT_W = 7
);
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             packet_abort;
    logic             dequeue;
    logic             is_empty;
    logic             is_full;
    logic [7:0]       sprite_id;
    logic [15:0]      sprite_x;
    logic [15:0]      sprite_y;
    logic [7:0]       sprite_scale;
    logic [CNT_W-1:0] count;
    logic             overflow;

    modport master (
        output byte_valid, byte_data, packet_abort, dequeue,
        input  is_empty, is_full, sprite_id, sprite_x, sprite_y, sprite_scale, count, overflow
    );

    modport slave (
        input  byte_valid, byte_data, packet_abort, dequeue,
        output is_empty, is_full, sprite_id, sprite_x, sprite_y, sprite_scale, count, overflow
    );
endinterface

// File: rtl/sprite_draw_queue.sv
// Parses host command bytes into sprite draw entries and buffers them in a
// show-ahead FIFO with flush, partial-packet abort and sticky overflow.
module sprite_draw_queue #(
    parameter int DEPTH = 64,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input logic              clock,
    input logic              reset,
    sprite_draw_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [0:0] {ST_IDLE, ST_PAYLOAD} state_t;

    state_t           state_reg;
    logic [2:0]       idx_reg;
    logic [39:0]      payload_reg;
    logic [47:0]      mem [DEPTH];
    logic [47:0]      head_reg;
    logic [47:0]      head_next;
    logic [47:0]      new_entry;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             overflow_reg;

    logic accept;
    logic cmd_flush;
    logic entry_done;
    logic do_deq;
    logic is_full_now;
    logic wr_en;
    logic drop;

    // Abort masks the byte so no parser or FIFO side-effect can happen that cycle.
    assign accept      = bus.byte_valid && !bus.packet_abort;
    assign cmd_flush   = accept && (state_reg == ST_IDLE) && (bus.byte_data == 8'h02);
    assign entry_done  = accept && (state_reg == ST_PAYLOAD) && (idx_reg == 3'd5);
    assign is_full_now = (count_reg == CNT_W'(DEPTH));
    assign do_deq      = bus.dequeue && (count_reg != '0) && !cmd_flush;
    assign wr_en       = entry_done && (!is_full_now || do_deq);
    assign drop        = entry_done && is_full_now && !do_deq;
    assign new_entry   = {payload_reg, bus.byte_data};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            idx_reg   <= 3'd0;
        end else if (bus.packet_abort) begin
            state_reg <= ST_IDLE;
            idx_reg   <= 3'd0;
        end else if (bus.byte_valid) begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.byte_data == 8'h01) begin
                        state_reg <= ST_PAYLOAD;
                        idx_reg   <= 3'd0;
                    end
                end
                ST_PAYLOAD: begin
                    if (idx_reg == 3'd5) begin
                        state_reg <= ST_IDLE;
                        idx_reg   <= 3'd0;
                    end else begin
                        idx_reg <= idx_reg + 3'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    idx_reg   <= 3'd0;
                end
            endcase
        end
    end

    // After five payload bytes the shifter holds id, x_hi, x_lo, y_hi, y_lo in order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            payload_reg <= '0;
        end else if (accept && (state_reg == ST_PAYLOAD) && (idx_reg != 3'd5)) begin
            payload_reg <= {payload_reg[31:0], bus.byte_data};
        end
    end

    always_comb begin
        count_next  = count_reg + CNT_W'(wr_en) - CNT_W'(do_deq);
        rd_ptr_next = do_deq ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
        if (cmd_flush) begin
            count_next  = '0;
            rd_ptr_next = wr_ptr_reg;
        end
    end

    // Head is a registered read at the next read pointer, bypassing a write that lands there.
    always_comb begin
        head_next = head_reg;
        if (wr_en && (wr_ptr_reg == rd_ptr_next)) begin
            head_next = new_entry;
        end else if (count_next != '0) begin
            head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= new_entry;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            head_reg     <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (cmd_flush) begin
                overflow_reg <= 1'b0;
            end else if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign bus.is_empty     = (count_reg == '0);
    assign bus.is_full      = is_full_now;
    assign bus.count        = count_reg;
    assign bus.overflow     = overflow_reg;
    assign bus.sprite_id    = head_reg[47:40];
    assign bus.sprite_x     = head_reg[39:24];
    assign bus.sprite_y     = head_reg[23:8];
    assign bus.sprite_scale = head_reg[7:0];
endmodule

// File: tb/tb_sprite_draw_queue.sv
// Randomised and directed checks of sprite_draw_queue against a packet-level queue model.
module tb_sprite_draw_queue;
    localparam int DEPTH = 64;
    localparam int CNT_W = 7;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    sprite_draw_queue_if #(.CNT_W(CNT_W)) bus ();

    sprite_draw_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: packets are collected as byte lists; the FIFO is a plain queue.
    logic [47:0] mq[$];
    logic [7:0]  pkt[$];
    logic        in_pkt;
    logic        m_ovf;

    task automatic model_reset();
        mq.delete();
        pkt.delete();
        in_pkt = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_apply(input logic v, input logic [7:0] b, input logic ab, input logic dq);
        int   pre_size;
        logic flush;
        logic deq_ok;
        logic done;
        logic [47:0] e;
        pre_size = mq.size();
        flush    = 1'b0;
        done     = 1'b0;
        e        = '0;
        if (ab) begin
            in_pkt = 1'b0;
            pkt.delete();
        end else if (v) begin
            if (!in_pkt) begin
                if (b == 8'h01) begin
                    in_pkt = 1'b1;
                    pkt.delete();
                end else if (b == 8'h02) begin
                    flush = 1'b1;
                end
            end else begin
                pkt.push_back(b);
                if (pkt.size() == 6) begin
                    e      = {pkt[0], pkt[1], pkt[2], pkt[3], pkt[4], pkt[5]};
                    done   = 1'b1;
                    in_pkt = 1'b0;
                    pkt.delete();
                end
            end
        end
        deq_ok = dq && (pre_size > 0) && !flush;
        if (flush) begin
            mq.delete();
            m_ovf = 1'b0;
        end
        if (deq_ok) void'(mq.pop_front());
        if (done) begin
            if (pre_size < DEPTH || deq_ok) mq.push_back(e);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic step(input logic v, input logic [7:0] b, input logic ab, input logic dq);
        bus.byte_valid   = v;
        bus.byte_data    = b;
        bus.packet_abort = ab;
        bus.dequeue      = dq;
        model_apply(v, b, ab, dq);
        @(posedge clk);
        #1;
        bus.byte_valid   = 1'b0;
        bus.packet_abort = 1'b0;
        bus.dequeue      = 1'b0;
    endtask

    task automatic send_draw(input logic [7:0] id, input logic [15:0] x, input logic [15:0] y,
                             input logic [7:0] s, input logic last_deq);
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, id, 1'b0, 1'b0);
        step(1'b1, x[15:8], 1'b0, 1'b0);
        step(1'b1, x[7:0], 1'b0, 1'b0);
        step(1'b1, y[15:8], 1'b0, 1'b0);
        step(1'b1, y[7:0], 1'b0, 1'b0);
        step(1'b1, s, 1'b0, last_deq);
        $display("draw id=%02h x=%04h y=%04h scale=%02h deq=%0b -> count=%0d", id, x, y, s, last_deq, bus.count);
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.byte_valid   = 1'b0;
        bus.byte_data    = 8'h00;
        bus.packet_abort = 1'b0;
        bus.dequeue      = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (bus.is_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", bus.is_empty); end
        n_vec++; if (bus.is_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", bus.is_full); end
        n_vec++; if (bus.count !== 7'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
        n_vec++; if ({bus.sprite_id, bus.sprite_x, bus.sprite_y, bus.sprite_scale} !== 48'h0) begin
            n_err++; $display("FAIL reset_head: got %h want 0", {bus.sprite_id, bus.sprite_x, bus.sprite_y, bus.sprite_scale});
        end
        $display("reset done");
    endtask

    task automatic test_basic();
        send_draw(8'h05, 16'h0010, 16'hFFF0, 8'h40, 1'b0);
        n_vec++; if (bus.is_empty !== 1'b0) begin n_err++; $display("FAIL basic_empty: got %b want 0", bus.is_empty); end
        n_vec++; if (bus.count !== 7'd1) begin n_err++; $display("FAIL basic_count: got %0d want 1", bus.count); end
        n_vec++; if (bus.sprite_id !== 8'h05) begin n_err++; $display("FAIL basic_id: got %h want 05", bus.sprite_id); end
        n_vec++; if (bus.sprite_x !== 16'h0010) begin n_err++; $display("FAIL basic_x: got %h want 0010", bus.sprite_x); end
        n_vec++; if ($signed(bus.sprite_y) !== -16) begin n_err++; $display("FAIL basic_y: got %0d want -16", $signed(bus.sprite_y)); end
        n_vec++; if (bus.sprite_scale !== 8'h40) begin n_err++; $display("FAIL basic_scale: got %h want 40", bus.sprite_scale); end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_vec++; if (bus.is_empty !== 1'b1) begin n_err++; $display("FAIL basic_deq_empty: got %b want 1", bus.is_empty); end
        n_vec++; if (bus.count !== 7'd0) begin n_err++; $display("FAIL basic_deq_count: got %0d want 0", bus.count); end
        $display("dequeue -> count=%0d", bus.count);
    endtask

    task automatic test_abort();
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h07, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);  // abort wins over a coincident byte
        $display("abort after 01 07 00 01");
        send_draw(8'h08, 16'h0002, 16'h0003, 8'h20, 1'b0);
        n_vec++; if (bus.count !== 7'd1) begin n_err++; $display("FAIL abort_count: got %0d want 1", bus.count); end
        n_vec++; if ({bus.sprite_id, bus.sprite_x, bus.sprite_y, bus.sprite_scale} !== 48'h08_0002_0003_20) begin
            n_err++; $display("FAIL abort_head: got %h want 080002000320", {bus.sprite_id, bus.sprite_x, bus.sprite_y, bus.sprite_scale});
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_vec++; if (bus.is_empty !== 1'b1) begin n_err++; $display("FAIL abort_drain: got %b want 1", bus.is_empty); end
    endtask

    task automatic test_fill_overflow();
        logic [7:0] exp_id;
        for (int i = 0; i < DEPTH; i++) begin
            send_draw(8'(i), 16'($urandom), 16'($urandom), 8'($urandom), 1'b0);
        end
        n_vec++; if (bus.is_full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", bus.is_full); end
        n_vec++; if (bus.count !== 7'd64) begin n_err++; $display("FAIL fill_count: got %0d want 64", bus.count); end
        n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL fill_ovf: got %b want 0", bus.overflow); end
        send_draw(8'hAA, 16'h1234, 16'h5678, 8'h9A, 1'b1);
        n_vec++; if (bus.count !== 7'd64) begin n_err++; $display("FAIL fulldeq_count: got %0d want 64", bus.count); end
        n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL fulldeq_ovf: got %b want 0", bus.overflow); end
        n_vec++; if (bus.sprite_id !== 8'h01) begin n_err++; $display("FAIL fulldeq_head: got %h want 01", bus.sprite_id); end
        send_draw(8'hBB, 16'h0000, 16'h0000, 8'h00, 1'b0);
        n_vec++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
        n_vec++; if (bus.count !== 7'd64) begin n_err++; $display("FAIL ovf_count: got %0d want 64", bus.count); end
        for (int i = 0; i < DEPTH; i++) begin
            exp_id = (i < DEPTH - 1) ? 8'(i + 1) : 8'hAA;
            n_vec++; if (bus.sprite_id !== exp_id) begin n_err++; $display("FAIL drain_id[%0d]: got %h want %h", i, bus.sprite_id, exp_id); end
            n_vec++; if ({bus.sprite_id, bus.sprite_x, bus.sprite_y, bus.sprite_scale} !== mq[0]) begin
                n_err++; $display("FAIL drain_head[%0d]: got %h want %h", i, {bus.sprite_id, bus.sprite_x, bus.sprite_y, bus.sprite_scale}, mq[0]);
            end
            step(1'b0, 8'h00, 1'b0, 1'b1);
        end
        n_vec++; if (bus.is_empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", bus.is_empty); end
        $display("drained %0d entries, count=%0d", DEPTH, bus.count);
    endtask

    task automatic test_flush();
        for (int i = 0; i <= DEPTH; i++) begin
            send_draw(8'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 1'b0);
        end
        repeat (DEPTH - 3) step(1'b0, 8'h00, 1'b0, 1'b1);
        n_vec++; if (bus.count !== 7'd3) begin n_err++; $display("FAIL preflush_count: got %0d want 3", bus.count); end
        n_vec++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL preflush_ovf: got %b want 1", bus.overflow); end
        step(1'b1, 8'h02, 1'b0, 1'b0);
        $display("flush -> count=%0d", bus.count);
        n_vec++; if (bus.count !== 7'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", bus.count); end
        n_vec++; if (bus.is_empty !== 1'b1) begin n_err++; $display("FAIL flush_empty: got %b want 1", bus.is_empty); end
        n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL flush_ovf: got %b want 0", bus.overflow); end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_vec++; if (bus.count !== 7'd0) begin n_err++; $display("FAIL underflow_count: got %0d want 0", bus.count); end
        send_draw(8'h11, 16'h0001, 16'h0001, 8'h01, 1'b0);
        send_draw(8'h22, 16'h0002, 16'h0002, 8'h02, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b1);  // flush beats a coincident dequeue
        n_vec++; if (bus.count !== 7'd0) begin n_err++; $display("FAIL flushdeq_count: got %0d want 0", bus.count); end
        send_draw(8'h33, 16'hFFFF, 16'h8000, 8'h7F, 1'b0);
        n_vec++; if ({bus.sprite_id, bus.sprite_x, bus.sprite_y, bus.sprite_scale} !== 48'h33_FFFF_8000_7F) begin
            n_err++; $display("FAIL postflush_head: got %h want 33ffff80007f", {bus.sprite_id, bus.sprite_x, bus.sprite_y, bus.sprite_scale});
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_garbage();
        step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        $display("garbage 55 00 FF -> count=%0d", bus.count);
        n_vec++; if (bus.count !== 7'd0) begin n_err++; $display("FAIL garbage_count: got %0d want 0", bus.count); end
        send_draw(8'h9C, 16'h0100, 16'h0200, 8'h10, 1'b0);
        n_vec++; if ({bus.sprite_id, bus.sprite_x, bus.sprite_y, bus.sprite_scale} !== 48'h9C_0100_0200_10) begin
            n_err++; $display("FAIL garbage_draw: got %h want 9c0100020010", {bus.sprite_id, bus.sprite_x, bus.sprite_y, bus.sprite_scale});
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        int   r;
        int   deq_pct;
        logic v;
        logic ab;
        logic dq;
        logic [7:0] b;
        logic [47:0] exp;
        int   errs_before;
        errs_before = n_err;
        for (int c = 0; c < 4000; c++) begin
            deq_pct = ((c / 1000) % 2 == 0) ? 8 : 45;
            r  = $urandom_range(0, 99);
            ab = (r < 2);
            v  = ($urandom_range(0, 99) < 70);
            dq = ($urandom_range(0, 99) < deq_pct);
            if (!in_pkt) begin
                r = $urandom_range(0, 99);
                b = (r < 75) ? 8'h01 : (r < 77) ? 8'h02 : 8'($urandom);
            end else begin
                b = 8'($urandom);
            end
            step(v, b, ab, dq);
            n_vec++; if (bus.count !== 7'(mq.size())) begin n_err++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, bus.count, mq.size()); end
            n_vec++; if (bus.is_empty !== (mq.size() == 0)) begin n_err++; $display("FAIL rnd_empty@%0d: got %b want %b", c, bus.is_empty, mq.size() == 0); end
            n_vec++; if (bus.is_full !== (mq.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full@%0d: got %b want %b", c, bus.is_full, mq.size() == DEPTH); end
            n_vec++; if (bus.overflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf@%0d: got %b want %b", c, bus.overflow, m_ovf); end
            if (mq.size() > 0) begin
                exp = mq[0];
                n_vec++; if ({bus.sprite_id, bus.sprite_x, bus.sprite_y, bus.sprite_scale} !== exp) begin
                    n_err++; $display("FAIL rnd_head@%0d: got %h want %h", c, {bus.sprite_id, bus.sprite_x, bus.sprite_y, bus.sprite_scale}, exp);
                end
            end
        end
        $display("random: 4000 cycles, %0d new miscompares, final count=%0d", n_err - errs_before, bus.count);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_abort();
        test_fill_overflow();
        test_flush();
        test_garbage();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
